button_conditioner: RTL and testbench

Front-end conditioner for the four clock/alarm pushbuttons, sitting directly upstream of the system's button PIO inputs: set_mode, inc_hour, inc_min and inc_sec. It synchronises and debounces the raw active-low keys, and generates press events with optional auto-repeat while a key is held. Each button is presented as an 8-bit status word for software to poll; software detects new presses by comparing the word against the previous read.

---
 rtl/button_conditioner.sv | 152 +++++++++++++++
 tb/tb_button_conditioner.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Pushbutton front end: 2-flop sync, debounce, press/auto-repeat events per key.
// Each channel exposes {event_count[5:0], event_toggle, pressed} for software polling.
module button_conditioner #(
   parameter int         DEBOUNCE_CYC = 1_000_000,
   parameter int         HOLD_CYC     = 25_000_000,
   parameter int         REPEAT_CYC   = 10_000_000,
   parameter logic [3:0] REPEAT_MASK  = 4'b1110
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic [3:0] btn_n_in,
   output logic [7:0] set_mode_button_export,
   output logic [7:0] inc_hour_button_export,
   output logic [7:0] inc_min_button_export,
   output logic [7:0] inc_sec_button_export
);

   localparam int DW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int HMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
   localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
   localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYC - 1);

   typedef enum logic [1:0] {
      ST_RELEASED = 2'd0,
      ST_HELD     = 2'd1,
      ST_REPEAT   = 2'd2
   } state_e;

   logic [7:0] word_s [4];

   for (genvar g = 0; g < 4; g++) begin : g_ch
      logic [1:0]    sync_q;
      logic          stable_q;
      logic          stable_d;
      logic [DW-1:0] db_cnt_q;
      logic [DW-1:0] db_cnt_d;
      logic [HW-1:0] hold_cnt_q;
      state_e        state_q;
      logic          evt_q;
      logic [7:0]    word_q;
      logic          pressed;
      logic          mismatch;
      logic          accept;

      assign pressed  = ~sync_q[1];
      assign mismatch = pressed ^ stable_q;
      assign accept   = mismatch && (db_cnt_q == DB_LAST);

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            sync_q <= 2'b11;
         end else begin
            sync_q <= {sync_q[0], btn_n_in[g]};
         end
      end

      // A change is taken only after DEBOUNCE_CYC consecutive mismatching cycles.
      always_comb begin
         stable_d = stable_q;
         db_cnt_d = '0;
         if (!mismatch) begin
            db_cnt_d = '0;
         end else if (accept) begin
            stable_d = pressed;
            db_cnt_d = '0;
         end else begin
            db_cnt_d = db_cnt_q + DW'(1);
         end
      end

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            stable_q <= 1'b0;
            db_cnt_q <= '0;
         end else begin
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
         end
      end

      // Release is checked first so it beats a repeat due in the same cycle.
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            state_q    <= ST_RELEASED;
            hold_cnt_q <= '0;
            evt_q      <= 1'b0;
         end else begin
            evt_q <= 1'b0;
            if (accept && !pressed) begin
               state_q    <= ST_RELEASED;
               hold_cnt_q <= '0;
            end else begin
               case (state_q)
                  ST_RELEASED: begin
                     hold_cnt_q <= '0;
                     if (accept && pressed) begin
                        evt_q   <= 1'b1;
                        state_q <= ST_HELD;
                     end
                  end
                  ST_HELD: begin
                     if (REPEAT_MASK[g]) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                           evt_q      <= 1'b1;
                           state_q    <= ST_REPEAT;
                           hold_cnt_q <= '0;
                        end else begin
                           hold_cnt_q <= hold_cnt_q + HW'(1);
                        end
                     end
                  end
                  ST_REPEAT: begin
                     if (hold_cnt_q == REP_LAST) begin
                        evt_q      <= 1'b1;
                        hold_cnt_q <= '0;
                     end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                     end
                  end
                  default: begin
                     state_q    <= ST_RELEASED;
                     hold_cnt_q <= '0;
                  end
               endcase
            end
         end
      end

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            word_q <= 8'h00;
         end else begin
            word_q[0] <= stable_q;
            if (evt_q) begin
               word_q[1]   <= ~word_q[1];
               word_q[7:2] <= word_q[7:2] + 6'd1;
            end
         end
      end

      assign word_s[g] = word_q;
   end

   assign set_mode_button_export = word_s[0];
   assign inc_hour_button_export = word_s[1];
   assign inc_min_button_export  = word_s[2];
   assign inc_sec_button_export  = word_s[3];

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboarded bench for button_conditioner: expected status words are scheduled
// per cycle from the latency/repeat timing rules and compared on the falling edge.
module tb_button_conditioner;

   localparam int         DB   = 4;
   localparam int         HOLD = 10;
   localparam int         REP  = 5;
   localparam logic [3:0] MASK = 4'b1110;

   logic       clk_clk       = 1'b0;
   logic       reset_reset_n = 1'b0;
   logic [3:0] btn_n_in      = 4'hF;
   logic [7:0] w0, w1, w2, w3;

   typedef struct {
      int         cyc;
      int         ch;
      logic [7:0] exp;
   } sb_t;

   sb_t  sbq [$];
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;
   int   cnt_m [4];
   logic tog_m [4];

   button_conditioner #(
      .DEBOUNCE_CYC (DB),
      .HOLD_CYC     (HOLD),
      .REPEAT_CYC   (REP),
      .REPEAT_MASK  (MASK)
   ) dut (
      .clk_clk                (clk_clk),
      .reset_reset_n          (reset_reset_n),
      .btn_n_in               (btn_n_in),
      .set_mode_button_export (w0),
      .inc_hour_button_export (w1),
      .inc_min_button_export  (w2),
      .inc_sec_button_export  (w3)
   );

   always #5 clk_clk = ~clk_clk;

   always @(posedge clk_clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] word_of(input int ch);
      case (ch)
         0:       return w0;
         1:       return w1;
         2:       return w2;
         default: return w3;
      endcase
   endfunction

   function automatic logic [7:0] mk_word(input int cnt, input logic tog, input logic lvl);
      logic [5:0] c6;
      c6 = cnt[5:0];
      return {c6, tog, lvl};
   endfunction

   task automatic sb_push(input int c, input int ch, input logic [7:0] exp);
      sb_t item;
      int  i;
      item.cyc = c;
      item.ch  = ch;
      item.exp = exp;
      i = sbq.size();
      while (i > 0 && sbq[i-1].cyc > c) i--;
      sbq.insert(i, item);
   endtask

   // Key falls at drive cycle n and rises at drive cycle m (both sampled on the next edge).
   task automatic sched(input int ch, input int n, input int m);
      int   a;
      int   r;
      int   e;
      int   k;
      int   base;
      logic tb0;
      int   ev [$];
      a    = n + DB + 2;
      r    = m + DB + 2;
      base = cnt_m[ch];
      tb0  = tog_m[ch];
      ev.push_back(a);
      if (MASK[ch]) begin
         e = a + HOLD;
         while (e < r) begin
            ev.push_back(e);
            e += REP;
         end
      end
      for (int c = a; c <= r + 1; c++) begin
         k = 0;
         foreach (ev[i]) if (ev[i] < c) k++;
         sb_push(c, ch, mk_word(base + k, tb0 ^ k[0], (c > a) && (c <= r)));
      end
      k = ev.size();
      cnt_m[ch] = base + k;
      tog_m[ch] = tb0 ^ k[0];
   endtask

   task automatic press(input int ch, input int lo, input int hi);
      int n;
      @(posedge clk_clk); #1;
      n = cyc;
      sched(ch, n, n + lo);
      btn_n_in[ch] = 1'b0;
      repeat (lo) @(posedge clk_clk);
      #1;
      btn_n_in[ch] = 1'b1;
      repeat (hi - 1) @(posedge clk_clk);
   endtask

   task automatic glitch(input int ch, input int lo, input int hi);
      int n;
      @(posedge clk_clk); #1;
      n = cyc;
      for (int c = n + 1; c <= n + lo + hi; c++) sb_push(c, ch, mk_word(cnt_m[ch], tog_m[ch], 1'b0));
      btn_n_in[ch] = 1'b0;
      repeat (lo) @(posedge clk_clk);
      #1;
      btn_n_in[ch] = 1'b1;
      repeat (hi - 1) @(posedge clk_clk);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (sbq.size() != 0 && t < 400) begin
         @(posedge clk_clk);
         t++;
      end
      check_eq("drain", sbq.size(), 0);
      sbq.delete();
   endtask

   task automatic clear_model();
      for (int i = 0; i < 4; i++) begin
         cnt_m[i] = 0;
         tog_m[i] = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk_clk); #3;
      reset_reset_n = 1'b0;
      btn_n_in      = 4'hF;
      clear_model();
      repeat (2) @(posedge clk_clk);
      #1;
      reset_reset_n = 1'b1;
   endtask

   always @(negedge clk_clk) begin
      sb_t e;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
         e = sbq.pop_front();
         if (e.cyc < cyc) check_eq("late", e.cyc, cyc);
         else check_eq($sformatf("ch%0d@%0d", e.ch, e.cyc), word_of(e.ch), e.exp);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      clear_model();

      // Reset state, then after release with all keys idle.
      repeat (3) @(posedge clk_clk);
      #1;
      for (int i = 0; i < 4; i++) check_eq($sformatf("rst_ch%0d", i), word_of(i), 8'h00);
      reset_reset_n = 1'b1;
      repeat (6) @(posedge clk_clk);
      #1;
      for (int i = 0; i < 4; i++) check_eq($sformatf("idle_ch%0d", i), word_of(i), 8'h00);

      // Asynchronous reset mid-hold on inc_min, key still held through release.
      @(posedge clk_clk); #1;
      btn_n_in[2] = 1'b0;
      repeat (12) @(posedge clk_clk);
      #1;
      check_eq("min_held", w2, 8'h07);
      #3;
      reset_reset_n = 1'b0;
      #1;
      check_eq("min_async_rst", w2, 8'h00);
      clear_model();
      repeat (2) @(posedge clk_clk);
      #1;
      reset_reset_n = 1'b1;
      r = cyc;
      sched(2, r, r + 8);
      repeat (8) @(posedge clk_clk);
      #1;
      btn_n_in[2] = 1'b1;
      wait_drain();
      check_eq("min_fresh_press", w2, 8'h06);

      // Single short press on inc_hour.
      press(1, 8, 8);
      wait_drain();

      // Bounces shorter than the debounce window on inc_min.
      repeat (5) glitch(2, 3, 5);
      wait_drain();

      // Long hold with auto-repeat on inc_sec; release ties with a due repeat.
      press(3, 30, 10);
      wait_drain();
      check_eq("sec_after_repeat", w3, 8'h16);

      // set_mode never repeats.
      press(0, 100, 10);
      wait_drain();

      // 64 presses wrap inc_hour while other channels run overlapping presses.
      do_reset();
      fork
         begin
            for (int i = 0; i < 64; i++) press(1, 8, 8);
         end
         begin
            repeat (3) press(3, 20, 8);
            press(0, 40, 8);
            press(2, 9, 9);
         end
      join
      wait_drain();
      check_eq("hour_wrap", w1, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
